// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Control unit and run sequencer for the single-cycle CPU datapath.
//   Decodes the 5-bit opcodeFunc field, evaluates branch conditions against
//   the C/Z flags and drives every datapath control strobe.  On top of plain
//   decode it provides run/halt/single-step control, programmable data-memory
//   wait states and return-stack depth fault tracking.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   run          in   level: 1 = execute, 0 = finish current instruction, idle
//   step_mode    in   1 = pause after every retired instruction
//   step         in   one-cycle pulse: leave PAUSE and execute one instruction
//   opcodeFunc   in   [4:0] opcode/function from instruction memory
//   halt         in   halt instruction flag from instruction memory
//   Cout, Zout   in   carry / zero flag registers
//   pcEn .. zWriteEn  out  datapath strobes (combinational from state/opcode)
//   aluOp        out  [3:0] ALU operation select
//   state_o      out  [2:0] IDLE=0 EXEC=1 MEM=2 PAUSE=3 HALTED=4 FAULT=5
//   fault        out  sticky stack overflow/underflow flag
//   retired      out  [CNT_W-1:0] saturating count of cycles with pcEn=1
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int MEM_WAIT    = 1,
  parameter int STACK_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step,
  input  logic [4:0]       opcodeFunc,
  input  logic             halt,
  input  logic             Cout,
  input  logic             Zout,
  output logic             pcEn,
  output logic             push,
  output logic             pop,
  output logic             memWriteEn,
  output logic             regWriteEn,
  output logic             immAndmem,
  output logic             stm,
  output logic             ldm,
  output logic             branch,
  output logic             jmp,
  output logic             ret,
  output logic             cWriteEn,
  output logic             zWriteEn,
  output logic [3:0]       aluOp,
  output logic [2:0]       state_o,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [4:0] OP_LDM = 5'b10100;
  localparam logic [4:0] OP_STM = 5'b10101;
  localparam logic [4:0] OP_JMP = 5'b10110;
  localparam logic [4:0] OP_JSB = 5'b10111;
  localparam logic [4:0] OP_RET = 5'b11000;
  localparam logic [4:0] OP_BZ  = 5'b11001;
  localparam logic [4:0] OP_BNZ = 5'b11010;
  localparam logic [4:0] OP_BC  = 5'b11011;
  localparam logic [4:0] OP_BNC = 5'b11100;

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int WW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(MEM_WAIT);
  localparam bit            MEM_STALL = (MEM_WAIT > 0);

  // Full set of strobes an instruction asserts in its retirement cycle (pcEn excluded).
  typedef struct packed {
    logic       push;
    logic       pop;
    logic       mem_we;
    logic       reg_we;
    logic       imm;
    logic       stm;
    logic       ldm;
    logic       branch;
    logic       jmp;
    logic       ret;
    logic       c_we;
    logic       z_we;
    logic [3:0] alu;
  } ctrl_t;

  function automatic ctrl_t f_decode(input logic [4:0] op, input logic c, input logic z);
    ctrl_t d;
    d = '0;
    casez (op)
      5'b00???: begin
        d.alu    = {1'b0, op[2:0]};
        d.reg_we = 1'b1;
        d.c_we   = 1'b1;
        d.z_we   = 1'b1;
      end
      5'b01???: begin
        d.alu    = {1'b0, op[2:0]};
        d.imm    = 1'b1;
        d.reg_we = 1'b1;
        d.c_we   = 1'b1;
        d.z_we   = 1'b1;
      end
      5'b100??: begin
        d.alu    = {2'b10, op[1:0]};
        d.imm    = 1'b1;
        d.reg_we = 1'b1;
        d.c_we   = 1'b1;
        d.z_we   = 1'b1;
      end
      OP_LDM: begin
        d.imm    = 1'b1;
        d.ldm    = 1'b1;
        d.reg_we = 1'b1;
      end
      OP_STM: begin
        d.imm    = 1'b1;
        d.stm    = 1'b1;
        d.mem_we = 1'b1;
      end
      OP_JMP: d.jmp = 1'b1;
      OP_JSB: begin
        d.jmp  = 1'b1;
        d.push = 1'b1;
      end
      OP_RET: begin
        d.ret = 1'b1;
        d.pop = 1'b1;
      end
      OP_BZ:   d.branch = z;
      OP_BNZ:  d.branch = ~z;
      OP_BC:   d.branch = c;
      OP_BNC:  d.branch = ~c;
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [2:0]       r_state;
  logic [WW-1:0]    r_wait;
  logic [4:0]       r_op;
  logic [DW-1:0]    r_depth;
  logic             r_fault;
  logic [CNT_W-1:0] r_retired;

  logic [2:0]       w_state_nxt;
  logic [WW-1:0]    w_wait_nxt;
  logic [4:0]       w_op_nxt;
  logic [DW-1:0]    w_depth_nxt;
  logic             w_fault_nxt;
  logic             w_pc_en;
  ctrl_t            w_ctrl;
  ctrl_t            w_dec;
  logic [4:0]       w_op;
  logic             w_is_mem;
  logic             w_stack_err;
  logic [2:0]       w_exit_state;

  // During the memory wait the latched opcode drives decode, so a changing
  // instruction bus cannot disturb the strobes of the stalled access.
  assign w_op        = (r_state == S_MEM) ? r_op : opcodeFunc;
  assign w_dec       = f_decode(w_op, Cout, Zout);
  assign w_is_mem    = (opcodeFunc == OP_LDM) || (opcodeFunc == OP_STM);
  assign w_stack_err = ((opcodeFunc == OP_JSB) && (r_depth == DEPTH_MAX)) ||
                       ((opcodeFunc == OP_RET) && (r_depth == {DW{1'b0}}));
  // Where to go once an instruction retires: run has priority over single-step.
  assign w_exit_state = (!run) ? S_IDLE : (step_mode ? S_PAUSE : S_EXEC);

  // Next-state, strobe decode and bookkeeping updates.
  always_comb begin
    w_ctrl      = '0;
    w_pc_en     = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_op_nxt    = r_op;
    w_depth_nxt = r_depth;
    w_fault_nxt = r_fault;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (halt) begin
          w_state_nxt = S_HALTED;
        end else if (w_stack_err) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = S_FAULT;
        end else if (w_is_mem && MEM_STALL) begin
          // Address phase only: write strobes and pcEn wait for the last MEM cycle.
          w_ctrl.alu  = w_dec.alu;
          w_ctrl.imm  = w_dec.imm;
          w_ctrl.ldm  = w_dec.ldm;
          w_ctrl.stm  = w_dec.stm;
          w_wait_nxt  = WAIT_LOAD;
          w_op_nxt    = opcodeFunc;
          w_state_nxt = S_MEM;
        end else begin
          w_ctrl      = w_dec;
          w_pc_en     = 1'b1;
          w_state_nxt = w_exit_state;
          if (w_dec.push) begin
            w_depth_nxt = r_depth + DW'(1);
          end else if (w_dec.pop) begin
            w_depth_nxt = r_depth - DW'(1);
          end else begin
            w_depth_nxt = r_depth;
          end
        end
      end
      S_MEM: begin
        w_ctrl.alu = w_dec.alu;
        w_ctrl.imm = w_dec.imm;
        w_ctrl.ldm = w_dec.ldm;
        w_ctrl.stm = w_dec.stm;
        // The counter decrements to zero in this cycle, so the access retires now.
        if (r_wait <= WW'(1)) begin
          w_ctrl.mem_we = w_dec.mem_we;
          w_ctrl.reg_we = w_dec.reg_we;
          w_pc_en       = 1'b1;
          w_wait_nxt    = {WW{1'b0}};
          w_state_nxt   = w_exit_state;
        end else begin
          w_wait_nxt = r_wait - WW'(1);
        end
      end
      S_PAUSE: begin
        if (step) begin
          w_state_nxt = S_EXEC;
        end else if (!run) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      S_FAULT:  w_state_nxt = S_FAULT;
      default: begin
        // Unreachable encodings are treated as a fault so control stays quiet.
        w_fault_nxt = 1'b1;
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  // State, wait counter, latched opcode, stack depth and fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wait  <= {WW{1'b0}};
      r_op    <= 5'd0;
      r_depth <= {DW{1'b0}};
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_op    <= w_op_nxt;
      r_depth <= w_depth_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= {CNT_W{1'b0}};
    end else if (w_pc_en && (r_retired != {CNT_W{1'b1}})) begin
      r_retired <= r_retired + CNT_W'(1);
    end else begin
      r_retired <= r_retired;
    end
  end

  assign pcEn       = w_pc_en;
  assign push       = w_ctrl.push;
  assign pop        = w_ctrl.pop;
  assign memWriteEn = w_ctrl.mem_we;
  assign regWriteEn = w_ctrl.reg_we;
  assign immAndmem  = w_ctrl.imm;
  assign stm        = w_ctrl.stm;
  assign ldm        = w_ctrl.ldm;
  assign branch     = w_ctrl.branch;
  assign jmp        = w_ctrl.jmp;
  assign ret        = w_ctrl.ret;
  assign cWriteEn   = w_ctrl.c_we;
  assign zWriteEn   = w_ctrl.z_we;
  assign aluOp      = w_ctrl.alu;
  assign state_o    = r_state;
  assign fault      = r_fault;
  assign retired    = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//   Directed scenarios followed by randomized stimulus.  Every cycle the DUT
//   outputs are compared with an instruction-level reference model that
//   derives strobes from opcode ranges and tracks run/pause/memory phases.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int MW = 1;
  localparam int SD = 2;
  localparam int CW = 4;
  localparam int RET_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run, step_mode, step, halt, Cout, Zout;
  logic [4:0]    opcodeFunc;
  logic          pcEn, push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm;
  logic          branch, jmp, ret, cWriteEn, zWriteEn;
  logic [3:0]    aluOp;
  logic [2:0]    state_o;
  logic          fault;
  logic [CW-1:0] retired;

  cpu_sequencer #(.MEM_WAIT(MW), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step),
    .opcodeFunc(opcodeFunc), .halt(halt), .Cout(Cout), .Zout(Zout),
    .pcEn(pcEn), .push(push), .pop(pop), .memWriteEn(memWriteEn),
    .regWriteEn(regWriteEn), .immAndmem(immAndmem), .stm(stm), .ldm(ldm),
    .branch(branch), .jmp(jmp), .ret(ret), .cWriteEn(cWriteEn),
    .zWriteEn(zWriteEn), .aluOp(aluOp), .state_o(state_o), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mode 0 idle, 1 exec, 2 mem wait, 3 paused, 4 halted, 5 fault
  int m_st, m_wait, m_op, m_depth, m_fault, m_ret;

  // memory address phase keeps only immAndmem, stm, ldm and aluOp
  localparam logic [15:0] ADDR_PHASE = 16'h0E0F;

  // {push,pop,memWE,regWE,imm,stm,ldm,branch,jmp,ret,cWE,zWE,alu[3:0]}
  function automatic logic [15:0] full_decode(int op, bit c, bit z);
    logic [3:0] alu;
    bit         br;
    alu = (op < 16) ? 4'(op % 8) : ((op < 20) ? 4'(8 + op % 4) : 4'd0);
    br  = (op == 25) ? z : (op == 26) ? !z : (op == 27) ? c : (op == 28) ? !c : 1'b0;
    return {op == 23, op == 24, op == 21, op <= 20, (op >= 8 && op <= 21),
            op == 21, op == 20, br, (op == 22 || op == 23), op == 24,
            op < 20, op < 20, alu};
  endfunction

  function automatic int after_retire(bit r, bit sm);
    return (!r) ? 0 : (sm ? 3 : 1);
  endfunction

  function automatic logic [24:0] obs_vec();
    return {pcEn, push, pop, memWriteEn, regWriteEn, immAndmem, stm, ldm,
            branch, jmp, ret, cWriteEn, zWriteEn, aluOp, state_o, fault, retired};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Asserts reset (possibly mid-instruction) and checks outputs drop at once.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_st = 0; m_wait = 0; m_op = 0; m_depth = 0; m_fault = 0; m_ret = 0;
    check("reset", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic cyc(input bit r, input bit sm, input bit st, input int op,
                     input bit h, input bit c, input bit z);
    logic [15:0] s;
    logic [24:0] expv;
    bit          pc;
    int          nxt;
    run = r; step_mode = sm; step = st; opcodeFunc = 5'(op);
    halt = h; Cout = c; Zout = z;
    #1;
    s = 16'd0; pc = 1'b0; nxt = m_st;
    case (m_st)
      0: nxt = r ? 1 : 0;
      1: begin
        if (h) begin
          nxt = 4;
        end else if ((op == 23 && m_depth == SD) || (op == 24 && m_depth == 0)) begin
          nxt = 5;
          m_fault = 1;
        end else if ((op == 20 || op == 21) && MW > 0) begin
          s = full_decode(op, c, z) & ADDR_PHASE;
          m_op = op;
          m_wait = MW;
          nxt = 2;
        end else begin
          s = full_decode(op, c, z);
          pc = 1'b1;
          nxt = after_retire(r, sm);
          if (op == 23) m_depth++;
          else if (op == 24) m_depth--;
        end
      end
      2: begin
        if (m_wait <= 1) begin
          s = full_decode(m_op, c, z);
          pc = 1'b1;
          nxt = after_retire(r, sm);
        end else begin
          s = full_decode(m_op, c, z) & ADDR_PHASE;
          m_wait--;
        end
      end
      3: nxt = st ? 1 : (!r ? 0 : 3);
      default: nxt = m_st;
    endcase
    // state/fault/retired show register contents from before this edge
    expv = {pc, s, 3'(m_st), (m_st == 5) ? 1'b1 : 1'b0, CW'(m_ret)};
    check($sformatf("cycle%0d_op%0d_mode%0d", n_checks, op, m_st), 32'(obs_vec()), 32'(expv));
    @(posedge clk);
    m_st = nxt;
    if (pc && m_ret < RET_MAX) m_ret++;
    @(negedge clk);
  endtask

  initial begin
    run = 1'b0; step_mode = 1'b0; step = 1'b0; opcodeFunc = 5'd0;
    halt = 1'b0; Cout = 1'b0; Zout = 1'b0; rst = 1'b1;

    // ADD; ADD; halt
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    check("add_retired", 32'(retired), 32'd2);
    check("add_halted", 32'(state_o), 32'd4);
    cyc(1, 0, 0, 3, 0, 1, 1);
    cyc(1, 0, 0, 23, 0, 1, 1);

    // LDM with one wait state; bus changes during the wait
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 20, 0, 0, 0);
    cyc(1, 0, 0, 9, 0, 0, 0);
    check("ldm_retired", 32'(retired), 32'd1);

    // branches and ALU forms
    cyc(1, 0, 0, 25, 0, 0, 1);
    cyc(1, 0, 0, 25, 0, 1, 0);
    cyc(1, 0, 0, 28, 0, 0, 0);
    cyc(1, 0, 0, 28, 0, 1, 0);
    cyc(1, 0, 0, 26, 0, 0, 0);
    cyc(1, 0, 0, 27, 0, 1, 1);
    cyc(1, 0, 0, 13, 0, 0, 0);
    cyc(1, 0, 0, 18, 0, 0, 0);
    cyc(1, 0, 0, 22, 0, 0, 0);

    // stack overflow
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 23, 0, 0, 0);
    cyc(1, 0, 0, 23, 0, 0, 0);
    cyc(1, 0, 0, 23, 0, 0, 0);
    check("ovf_fault", 32'(fault), 32'd1);
    check("ovf_state", 32'(state_o), 32'd5);
    cyc(1, 0, 0, 24, 0, 0, 0);

    // stack underflow
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 24, 0, 0, 0);
    check("unf_fault", 32'(fault), 32'd1);
    check("unf_state", 32'(state_o), 32'd5);

    // single-step
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    check("step_paused", 32'(state_o), 32'd3);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 2, 0, 0, 0);
    check("step_back", 32'(state_o), 32'd3);
    check("step_retired", 32'(retired), 32'd2);

    // run dropped during STM wait
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 21, 0, 0, 0);
    cyc(0, 0, 0, 21, 0, 0, 0);
    check("stm_idle", 32'(state_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a memory wait
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 20, 0, 0, 0);
    do_reset();

    // retired saturation
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < RET_MAX + 3; i++) cyc(1, 0, 0, 31, 0, 0, 0);
    check("retired_sat", 32'(retired), 32'(RET_MAX));

    // randomized
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ((m_st >= 4 && $urandom_range(0, 3) == 0) ||
          (m_st == 2 && $urandom_range(0, 9) == 0)) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 31)),
            $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
